fir_stream_driver: RTL and testbench

- Host-side driver for the FIR filter's sample handshake; it is the producer/consumer end of the filter's `next`/`in`/`ready`/`out`/`stop` interface.
- Holds a host-loaded sample buffer and resets the filter. It presents one sample per `fir_next` request and captures each filter output into a result buffer.
- After the programmed sample count it asserts stop, captures the final output and reports done.
- Sits between the host/testbench register interface and the FIR core.

---
 rtl/fir_stream_driver_if.sv | 23 ++
 rtl/fir_stream_driver.sv | 152 +++++++++++++++
 tb/tb_fir_stream_driver.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_stream_driver_if.sv
// FIR core sample handshake: reset/stop/sample towards the core, request/valid/result back.
interface fir_stream_driver_if #(
   parameter int DATA_W = 32
);
   logic              fir_rst;
   logic [DATA_W-1:0] fir_in;
   logic              fir_stop;
   logic              fir_next;
   logic              fir_ready;
   logic [DATA_W-1:0] fir_out;

   // Driver side: owns reset, stop and the presented sample.
   modport master (
      output fir_rst, fir_in, fir_stop,
      input  fir_next, fir_ready, fir_out
   );

   // FIR core side: requests samples and returns results.
   modport slave (
      input  fir_rst, fir_in, fir_stop,
      output fir_next, fir_ready, fir_out
   );
endinterface

// File: rtl/fir_stream_driver.sv
// Host-side streaming driver for the FIR core: resets the core, feeds one buffered
// sample per fir_next request, captures ready-qualified results, then stops and drains.
module fir_stream_driver #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 146,
   parameter int AW     = 8,
   parameter int FLUSH  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_en,
   input  logic [AW-1:0]     ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [AW-1:0]     num_samples,
   input  logic              go,
   fir_stream_driver_if.master fir,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [AW:0]       res_count,
   output logic              busy,
   output logic              done
);
   typedef enum logic [2:0] {S_IDLE, S_RSTF, S_FEED, S_DRAIN, S_DONE} state_t;

   localparam int              FW      = $clog2(FLUSH + 1);
   localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [FW-1:0]   FLUSH_C = FW'(FLUSH);

   state_t            state;
   logic [DATA_W-1:0] sample_mem [DEPTH];
   logic [DATA_W-1:0] result_mem [DEPTH];
   logic [AW:0]       n_lat;
   logic [AW:0]       n_clamped;
   logic [AW-1:0]     idx;
   logic [AW-1:0]     idx_nxt;
   logic [FW-1:0]     flush_cnt;
   logic              rstf_cnt;
   logic              fir_next_d;
   logic              rise;
   logic              fall;
   logic              res_we;

   assign rise    = fir.fir_next & ~fir_next_d;
   assign fall    = ~fir.fir_next & fir_next_d;
   assign idx_nxt = idx + 1'b1;
   assign busy    = (state == S_RSTF) || (state == S_FEED) || (state == S_DRAIN);
   assign done    = (state == S_DONE);
   assign rd_data = ({1'b0, rd_addr} < DEPTH_C) ? result_mem[rd_addr] : '0;

   // Clamp the requested sample count into 1..DEPTH before it is latched.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      n_clamped = {1'b0, num_samples};
      if (num_samples == '0) begin
         n_clamped = (AW+1)'(1);
      end else if ({1'b0, num_samples} > DEPTH_C) begin
         n_clamped = DEPTH_C;
      end
   end

   // Result capture strobe: ready-qualified fall in FEED, or the final drain capture; saturates at DEPTH.
   always_comb begin
      res_we = 1'b0;
      if (fir.fir_ready && (res_count < DEPTH_C)) begin
         if ((state == S_FEED) && fall && !rise) begin
            res_we = 1'b1;
         end else if ((state == S_DRAIN) && (flush_cnt == FLUSH_C)) begin
            res_we = 1'b1;
         end
      end
   end

   // Host writes into the sample buffer, blocked while a run is in progress.
   always_ff @(posedge clk) begin
      // NOTE: the buffers have no reset so they map onto plain RAM; contents stay undefined until written.
      if (ld_en && !busy && ({1'b0, ld_addr} < DEPTH_C)) begin
         sample_mem[ld_addr] <= ld_data;
      end
   end

   // Result buffer write port.
   always_ff @(posedge clk) begin
      if (res_we) begin
         result_mem[res_count[AW-1:0]] <= fir.fir_out;
      end
   end

   // Run sequencer: core reset, sample feed on fir_next rises, stop and drain, done.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state        <= S_IDLE;
         fir.fir_rst  <= 1'b1;
         fir.fir_stop <= 1'b0;
         fir.fir_in   <= '0;
         idx          <= '0;
         res_count    <= '0;
         n_lat        <= (AW+1)'(1);
         flush_cnt    <= '0;
         rstf_cnt     <= 1'b0;
         fir_next_d   <= 1'b0;
      end else begin
         fir_next_d <= fir.fir_next;
         if (res_we) begin
            res_count <= res_count + 1'b1;
         end
         unique case (state)
            S_IDLE, S_DONE: begin
               fir.fir_rst <= 1'b1;
               if (go) begin
                  n_lat        <= n_clamped;
                  idx          <= '0;
                  res_count    <= '0;
                  fir.fir_in   <= sample_mem[0];
                  fir.fir_stop <= 1'b0;
                  rstf_cnt     <= 1'b0;
                  state        <= S_RSTF;
               end
            end
            S_RSTF: begin
               if (rstf_cnt) begin
                  fir.fir_rst <= 1'b0;
                  state       <= S_FEED;
               end else begin
                  rstf_cnt <= 1'b1;
               end
            end
            S_FEED: begin
               if (rise) begin
                  if ({1'b0, idx_nxt} == n_lat) begin
                     fir.fir_stop <= 1'b1;
                     flush_cnt    <= '0;
                     state        <= S_DRAIN;
                  end else begin
                     idx        <= idx_nxt;
                     fir.fir_in <= sample_mem[idx_nxt];
                  end
               end
            end
            S_DRAIN: begin
               if (flush_cnt == FLUSH_C) begin
                  fir.fir_rst <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  flush_cnt <= flush_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed bench for fir_stream_driver with a behavioural FIR core and result scoreboard.
module tb_fir_stream_driver;
   localparam int          DW    = 32;
   localparam int          DEPTH = 146;
   localparam int          AW    = 8;
   localparam int          FLUSH = 8;
   localparam int          FILL  = 2;
   localparam logic [DW-1:0] ONE = 32'h3f80_0000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;
   logic [AW-1:0] num_samples = '0;
   logic          go = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic [AW:0]   res_count;
   logic          busy;
   logic          done;

   fir_stream_driver_if #(.DATA_W(DW)) fir ();

   fir_stream_driver #(.DATA_W(DW), .DEPTH(DEPTH), .AW(AW), .FLUSH(FLUSH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ld_en       (ld_en),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .num_samples (num_samples),
      .go          (go),
      .fir         (fir),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .res_count   (res_count),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] shadow [DEPTH];
   logic [DW-1:0] x_hist [DEPTH];
   logic [DW-1:0] exp_samp [$];
   logic [DW-1:0] exp_res [$];
   int            rises_total = 0;
   int            rise_base = 0;
   int            run_n = 0;
   int            ph = 0;
   int            m_rise = 0;
   int            m_fall = 0;
   logic          stopped = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] coef(input int i);
      return 32'd1000 + 32'(i * 7);
   endfunction

   // Bench-side expected output for sample k from the host's view of the buffer.
   function automatic logic [DW-1:0] exp_y(input int k);
      logic [DW-1:0] acc = '0;
      for (int i = 0; i <= k; i++) if (shadow[k-i] == ONE) acc += coef(i);
      return acc;
   endfunction

   // Core-side output from the samples the model actually latched.
   function automatic logic [DW-1:0] model_y(input int k);
      logic [DW-1:0] acc = '0;
      for (int i = 0; i <= k; i++) if (x_hist[k-i] == ONE) acc += coef(i);
      return acc;
   endfunction

   // Behavioural FIR core: raise next and latch fir_in, drop next two cycles later with ready after FILL falls.
   always @(negedge clk) begin
      if (fir.fir_rst) begin
         fir.fir_next  = 1'b0;
         fir.fir_ready = 1'b0;
         fir.fir_out   = '0;
         ph = 0; m_rise = 0; m_fall = 0; stopped = 1'b0;
      end else if (fir.fir_stop) begin
         if (!stopped) begin
            fir.fir_next  = 1'b0;
            fir.fir_ready = 1'b1;
            fir.fir_out   = model_y(m_rise - 1);
            stopped = 1'b1;
         end
      end else begin
         ph++;
         if (ph == 2) begin
            fir.fir_next = 1'b1;
            if (m_rise < DEPTH) x_hist[m_rise] = fir.fir_in;
            m_rise++;
            rises_total++;
            check("rise_expected", 64'(exp_samp.size() != 0), 1);
            if (exp_samp.size() != 0) check("fir_in_at_rise", fir.fir_in, exp_samp.pop_front());
         end else if (ph == 4) begin
            fir.fir_next  = 1'b0;
            m_fall++;
            fir.fir_ready = (m_fall > FILL);
            fir.fir_out   = model_y(m_fall - 1);
            ph = 0;
         end
      end
   end

   task automatic load_word(input int a, input logic [DW-1:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = AW'(a); ld_data = d; shadow[a] = d;
   endtask

   task automatic load_end();
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic start_run(input int n);
      int ne;
      ne = (n == 0) ? 1 : ((n > DEPTH) ? DEPTH : n);
      exp_samp.delete();
      exp_res.delete();
      for (int k = 0; k < ne; k++) exp_samp.push_back(shadow[k]);
      for (int j = 1; j < ne; j++) if (j > FILL) exp_res.push_back(exp_y(j - 1));
      exp_res.push_back(exp_y(ne - 1));
      run_n = ne;
      rise_base = rises_total;
      @(negedge clk);
      num_samples = AW'(n); go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      check("rstf1_fir_rst", fir.fir_rst, 1);
      check("rstf1_fir_stop", fir.fir_stop, 0);
      check("rstf1_busy", busy, 1);
      check("rstf1_done", done, 0);
      check("rstf1_res_count", res_count, 0);
      check("rstf1_fir_in", fir.fir_in, shadow[0]);
      @(posedge clk); #1;
      check("rstf2_fir_rst", fir.fir_rst, 1);
      check("rstf2_fir_in", fir.fir_in, shadow[0]);
      @(posedge clk); #1;
      check("feed_fir_rst", fir.fir_rst, 0);
   endtask

   task automatic finish_run();
      int cyc = 0;
      int drain = 0;
      while (!done && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
         if (busy && fir.fir_stop) drain++;
      end
      check("done_reached", done, 1);
      check("drain_cycles", drain, FLUSH + 1);
      check("rise_count", rises_total - rise_base, run_n);
      check("samples_left", exp_samp.size(), 0);
      check("done_busy", busy, 0);
      check("done_fir_rst", fir.fir_rst, 1);
      check("done_fir_stop", fir.fir_stop, 1);
      check("res_count", res_count, exp_res.size());
      for (int a = 0; exp_res.size() > 0; a++) begin
         rd_addr = AW'(a);
         #1;
         check("result_word", rd_data, exp_res.pop_front());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_fir_rst", fir.fir_rst, 1);
      check("rst_fir_stop", fir.fir_stop, 0);
      check("rst_fir_in", fir.fir_in, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_res_count", res_count, 0);
      rst_n = 1'b1;

      // Constant 1.0 stream, N=10.
      for (int i = 0; i < DEPTH; i++) load_word(i, (i < 10) ? ONE : (32'h4000_0000 + 32'(i)));
      load_end();
      start_run(10);
      finish_run();

      // Impulse, N=73.
      for (int i = 0; i < DEPTH; i++) load_word(i, (i == 0) ? ONE : 32'h0);
      load_end();
      start_run(73);
      finish_run();

      // N=0 clamps to one sample; N beyond DEPTH clamps to DEPTH.
      start_run(0);
      finish_run();
      start_run(200);
      finish_run();

      // Asynchronous reset mid-feed at idx=5, then replay from sample 0.
      for (int i = 0; i < 10; i++) load_word(i, ONE);
      load_end();
      start_run(10);
      for (int c = 0; c < 200 && (rises_total - rise_base) < 5; c++) @(negedge clk);
      check("reach_idx5", rises_total - rise_base, 5);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midrst_fir_rst", fir.fir_rst, 1);
      check("midrst_fir_stop", fir.fir_stop, 0);
      check("midrst_fir_in", fir.fir_in, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_res_count", res_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      start_run(10);
      finish_run();

      // ld_en and go while busy are ignored.
      start_run(10);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = '0; ld_data = 32'hdead_beef;
      go = 1'b1; num_samples = AW'(3);
      @(negedge clk);
      ld_en = 1'b0; go = 1'b0;
      finish_run();
      start_run(10);
      finish_run();

      // Back-to-back run from DONE with N=4.
      check("b2b_done_before", done, 1);
      start_run(4);
      finish_run();

      // Out-of-range read address.
      rd_addr = AW'(200);
      #1;
      check("rd_out_of_range", rd_data, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
